instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
Front end of the 16-bit CPU that produces the instruction word and load strobe consumed by the instruction register.
- Owns the program counter and issues single-word read requests to instruction memory.
- Waits out memory wait states, then presents the fetched word on `insin` with a one-cycle `loadIR` pulse.
- Accepts jump redirects from the control unit.

Parameters:
- DATA_WIDTH, 16, instruction/memory data width (from CPU_package).
- ALU_OPCODE, 4, opcode field is ALU_OPCODE+1 = 5 bits (from CPU_package).
- ADDR_WIDTH, DATA_WIDTH-ALU_OPCODE-1 = 11, PC and memory address width.

Ports:
- iclk  in  1  system clock, all state updates on rising edge.
- irst  in  1  synchronous, active-high reset.
- fetch_en  in  1  control unit request for the next instruction; sampled only in IDLE.
- jump  in  1  redirect request; PC loads jump_addr.
- jump_addr  in  ADDR_WIDTH  redirect target.
- mem_rd  out  1  read request to instruction memory.
- mem_addr  out  ADDR_WIDTH  read address; valid while mem_rd=1.
- mem_ready  in  1  memory has mem_data valid this cycle; only meaningful while mem_rd=1.
- mem_data  in  DATA_WIDTH  instruction word from memory.
- insin  out  DATA_WIDTH  fetched instruction to the instruction register.
- loadIR  out  1  one-cycle load strobe to the instruction register.
- pc  out  ADDR_WIDTH  current program counter, i.e. address of the next fetch.
- busy  out  1  high when state != IDLE.

Behaviour:
- Clock and reset: one clock, iclk. Reset is synchronous and active-high on irst.
- Reset values: state=IDLE, pc=0, mem_rd=0, mem_addr=0, insin=0, loadIR=0, busy=0.
- Reset mid-operation: irst overrides everything in the same edge, including an outstanding request. Any mem_ready arriving afterwards is ignored.

States: IDLE, REQ, LOAD.

IDLE:
- If jump=1: pc<=jump_addr, stay IDLE. Jump has priority over fetch_en in the same cycle.
- Else if fetch_en=1: mem_addr<=pc, mem_rd<=1, go REQ.
- Otherwise hold.

REQ:
- mem_rd and mem_addr are held stable until the request completes or is aborted.
- If jump=1: abort.
  - mem_rd<=0, pc<=jump_addr, go IDLE, no loadIR.
  - Abort takes priority even if mem_ready=1 in the same cycle; that data is discarded.
- Else if mem_ready=1: complete.
  - insin<=mem_data, loadIR<=1, mem_rd<=0.
  - pc<=pc+1, wrapping modulo 2^ADDR_WIDTH (2047 -> 0).
  - Go LOAD.
- Else hold (wait state). There is no wait-state limit.

LOAD:
- loadIR<=0, go IDLE.
- fetch_en is ignored.
- jump in LOAD is honoured: pc<=jump_addr, overriding the increment just made.

General rules:
- loadIR is high for exactly one cycle per completed fetch. insin is valid and stable whenever loadIR=1.
- insin holds its value until the next completed fetch; aborts and jumps do not change it.
- Latency: fetch_en sampled at edge N gives mem_rd=1 after N. With mem_ready=1 in that cycle, loadIR=1 after edge N+1. The IR captures the word at edge N+2. Each wait cycle adds one.
- fetch_en while busy=1 is ignored, not queued.
- mem_data is sampled only in REQ with mem_ready=1. mem_ready outside REQ has no effect.

Test Plan:
- Reset, then fetch_en=1 for one cycle, mem_ready tied 1, mem_data=16'h4816 ({5'b01001,11'd22}) -> mem_rd=1 with mem_addr=0 for one cycle; loadIR=1 for one cycle with insin=16'h4816; pc=1; busy back to 0 after LOAD.
- mem_ready held low for 3 cycles after mem_rd rises, then high with mem_data=16'hC064 -> mem_rd/mem_addr stable for 4 cycles; a single loadIR pulse; insin=16'hC064; pc incremented once.
- jump=1, jump_addr=11'd100 in IDLE, then fetch -> mem_addr=100; after completion pc=101. jump and fetch_en in the same IDLE cycle -> pc=jump_addr, no request issued.
- Jump during REQ with mem_ready=1 in the same cycle, jump_addr=11'd11 -> mem_rd drops next edge, no loadIR, insin unchanged, pc=11, state IDLE.
- Wrap-around: jump to 11'd2047, fetch completes -> mem_addr=2047, pc=0.
- irst asserted while in REQ (mem_ready low), then mem_ready pulsed -> all outputs at reset values, no loadIR, pc=0.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_unit
// Brief    : PC owner and single-word instruction fetcher feeding the IR.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit #(
    parameter int DATA_WIDTH = 16,
    parameter int ALU_OPCODE = 4,
    parameter int ADDR_WIDTH = DATA_WIDTH - ALU_OPCODE - 1
) (
    input  logic                  iclk,
    input  logic                  irst,
    input  logic                  fetch_en,
    input  logic                  jump,
    input  logic [ADDR_WIDTH-1:0] jump_addr,
    output logic                  mem_rd,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic [DATA_WIDTH-1:0] insin,
    output logic                  loadIR,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_LOAD = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [ADDR_WIDTH-1:0]   r_pc;
    logic [ADDR_WIDTH-1:0]   w_pc_next;
    logic                    r_mem_rd;
    logic                    w_mem_rd_next;
    logic [ADDR_WIDTH-1:0]   r_mem_addr;
    logic [ADDR_WIDTH-1:0]   w_mem_addr_next;
    logic [DATA_WIDTH-1:0]   r_insin;
    logic [DATA_WIDTH-1:0]   w_insin_next;
    logic                    r_load_ir;
    logic                    w_load_ir_next;

    always_ff @(posedge iclk) begin
        if (irst) begin
            r_state    <= ST_IDLE;
            r_pc       <= '0;
            r_mem_rd   <= 1'b0;
            r_mem_addr <= '0;
            r_insin    <= '0;
            r_load_ir  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_pc       <= w_pc_next;
            r_mem_rd   <= w_mem_rd_next;
            r_mem_addr <= w_mem_addr_next;
            r_insin    <= w_insin_next;
            r_load_ir  <= w_load_ir_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_pc_next       = r_pc;
        w_mem_rd_next   = r_mem_rd;
        w_mem_addr_next = r_mem_addr;
        w_insin_next    = r_insin;
        w_load_ir_next  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (jump) begin
                    w_pc_next = jump_addr;
                end else if (fetch_en) begin
                    w_mem_addr_next = r_pc;
                    w_mem_rd_next   = 1'b1;
                    w_state_next    = ST_REQ;
                end
            end
            ST_REQ: begin
                // An abort wins over a same-cycle completion; that word is dropped.
                if (jump) begin
                    w_mem_rd_next = 1'b0;
                    w_pc_next     = jump_addr;
                    w_state_next  = ST_IDLE;
                end else if (mem_ready) begin
                    w_insin_next   = mem_data;
                    w_load_ir_next = 1'b1;
                    w_mem_rd_next  = 1'b0;
                    w_pc_next      = r_pc + ADDR_WIDTH'(1);
                    w_state_next   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (jump) begin
                    w_pc_next = jump_addr;
                end
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next  = ST_IDLE;
                w_mem_rd_next = 1'b0;
            end
        endcase
    end

    assign mem_rd   = r_mem_rd;
    assign mem_addr = r_mem_addr;
    assign insin    = r_insin;
    assign loadIR   = r_load_ir;
    assign pc       = r_pc;
    assign busy     = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_fetch_unit
// Brief    : Directed scenarios plus randomized run against a fetch model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_unit;

    localparam int DW = 16;
    localparam int AW = 11;

    logic          clk = 1'b0;
    logic          rst;
    logic          fetch_en;
    logic          jump;
    logic [AW-1:0] jump_addr;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic          mem_ready;
    logic [DW-1:0] mem_data;
    logic [DW-1:0] insin;
    logic          loadIR;
    logic [AW-1:0] pc;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    // Transaction-level view: is a read outstanding, is a load strobe showing.
    bit            m_req;
    bit            m_load;
    logic [AW-1:0] m_pc;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_insin;

    instruction_fetch_unit #(.DATA_WIDTH(16), .ALU_OPCODE(4)) dut (
        .iclk      (clk),
        .irst      (rst),
        .fetch_en  (fetch_en),
        .jump      (jump),
        .jump_addr (jump_addr),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_ready (mem_ready),
        .mem_data  (mem_data),
        .insin     (insin),
        .loadIR    (loadIR),
        .pc        (pc),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; fetch_en = 1'b0; jump = 1'b0;
        jump_addr = '0; mem_ready = 1'b0; mem_data = '0;
    endtask

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_step();
        if (rst) begin
            m_req = 0; m_load = 0; m_pc = '0; m_addr = '0; m_insin = '0;
        end else if (m_load) begin
            m_load = 0;
            if (jump) m_pc = jump_addr;
        end else if (m_req) begin
            if (jump) begin
                m_req = 0;
                m_pc  = jump_addr;
            end else if (mem_ready) begin
                m_req   = 0;
                m_load  = 1;
                m_insin = mem_data;
                m_pc    = AW'((int'(m_pc) + 1) % 2048);
            end
        end else if (jump) begin
            m_pc = jump_addr;
        end else if (fetch_en) begin
            m_addr = m_pc;
            m_req  = 1;
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1; mem_ready = 1'b1; fetch_en = 1'b1;
        tick(); tick();
        idle_inputs();
        checks++;
        if ({mem_rd, mem_addr, insin, loadIR, pc, busy} !== '0) begin
            failures++;
            $display("FAIL reset_values: got rd=%0b addr=%0d ins=%h ld=%0b pc=%0d busy=%0b, want all zero",
                     mem_rd, mem_addr, insin, loadIR, pc, busy);
        end
    endtask

    task automatic test_basic_fetch();
        fetch_en = 1'b1; mem_ready = 1'b1; mem_data = 16'h4816;
        tick();
        fetch_en = 1'b0;
        checks++;
        if (mem_rd !== 1'b1 || mem_addr !== 11'd0 || loadIR !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_req: rd=%0b addr=%0d ld=%0b busy=%0b, want 1 0 0 1", mem_rd, mem_addr, loadIR, busy);
        end
        tick();
        checks++;
        if (loadIR !== 1'b1 || insin !== 16'h4816 || mem_rd !== 1'b0 || pc !== 11'd1) begin
            failures++;
            $display("FAIL basic_load: ld=%0b ins=%h rd=%0b pc=%0d, want 1 4816 0 1", loadIR, insin, mem_rd, pc);
        end
        tick();
        checks++;
        if (loadIR !== 1'b0 || busy !== 1'b0 || insin !== 16'h4816) begin
            failures++;
            $display("FAIL basic_done: ld=%0b busy=%0b ins=%h, want 0 0 4816", loadIR, busy, insin);
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_wait_states();
        int pulses = 0;
        fetch_en = 1'b1; mem_ready = 1'b0;
        tick();
        fetch_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem_rd !== 1'b1 || mem_addr !== 11'd1 || loadIR !== 1'b0) begin
                failures++;
                $display("FAIL wait_hold[%0d]: rd=%0b addr=%0d ld=%0b, want 1 1 0", i, mem_rd, mem_addr, loadIR);
            end
            if (i == 3) begin
                mem_ready = 1'b1; mem_data = 16'hC064;
            end
            tick();
        end
        mem_ready = 1'b0;
        checks++;
        if (loadIR !== 1'b1 || insin !== 16'hC064 || pc !== 11'd2) begin
            failures++;
            $display("FAIL wait_load: ld=%0b ins=%h pc=%0d, want 1 c064 2", loadIR, insin, pc);
        end
        for (int i = 0; i < 4; i++) begin
            pulses += int'(loadIR);
            tick();
        end
        checks++;
        if (pulses != 1 || pc !== 11'd2) begin
            failures++;
            $display("FAIL wait_single_pulse: pulses=%0d pc=%0d, want 1 2", pulses, pc);
        end
    endtask

    task automatic test_jump();
        jump = 1'b1; jump_addr = 11'd100;
        tick();
        jump = 1'b0;
        checks++;
        if (pc !== 11'd100 || busy !== 1'b0 || mem_rd !== 1'b0) begin
            failures++;
            $display("FAIL jump_idle: pc=%0d busy=%0b rd=%0b, want 100 0 0", pc, busy, mem_rd);
        end
        fetch_en = 1'b1; mem_ready = 1'b1; mem_data = 16'h1234;
        tick();
        fetch_en = 1'b0;
        checks++;
        if (mem_addr !== 11'd100 || mem_rd !== 1'b1) begin
            failures++;
            $display("FAIL jump_fetch_addr: addr=%0d rd=%0b, want 100 1", mem_addr, mem_rd);
        end
        tick();
        checks++;
        if (pc !== 11'd101 || loadIR !== 1'b1 || insin !== 16'h1234) begin
            failures++;
            $display("FAIL jump_fetch_done: pc=%0d ld=%0b ins=%h, want 101 1 1234", pc, loadIR, insin);
        end
        tick();
        mem_ready = 1'b0;
        jump = 1'b1; jump_addr = 11'd50; fetch_en = 1'b1;
        tick();
        jump = 1'b0; fetch_en = 1'b0;
        checks++;
        if (pc !== 11'd50 || mem_rd !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL jump_priority: pc=%0d rd=%0b busy=%0b, want 50 0 0", pc, mem_rd, busy);
        end
    endtask

    task automatic test_abort();
        logic [DW-1:0] prev;
        prev = insin;
        fetch_en = 1'b1; mem_ready = 1'b0;
        tick();
        fetch_en = 1'b0;
        jump = 1'b1; jump_addr = 11'd11; mem_ready = 1'b1; mem_data = 16'hFFFF;
        tick();
        jump = 1'b0; mem_ready = 1'b0;
        checks++;
        if (mem_rd !== 1'b0 || loadIR !== 1'b0 || insin !== prev || pc !== 11'd11 || busy !== 1'b0) begin
            failures++;
            $display("FAIL abort: rd=%0b ld=%0b ins=%h pc=%0d busy=%0b, want 0 0 %h 11 0",
                     mem_rd, loadIR, insin, pc, busy, prev);
        end
        tick();
        checks++;
        if (loadIR !== 1'b0 || insin !== prev) begin
            failures++;
            $display("FAIL abort_after: ld=%0b ins=%h, want 0 %h", loadIR, insin, prev);
        end
    endtask

    task automatic test_wrap();
        jump = 1'b1; jump_addr = 11'd2047;
        tick();
        jump = 1'b0;
        fetch_en = 1'b1; mem_ready = 1'b1; mem_data = 16'hA5A5;
        tick();
        fetch_en = 1'b0;
        checks++;
        if (mem_addr !== 11'd2047 || mem_rd !== 1'b1) begin
            failures++;
            $display("FAIL wrap_addr: addr=%0d rd=%0b, want 2047 1", mem_addr, mem_rd);
        end
        tick();
        mem_ready = 1'b0;
        checks++;
        if (pc !== 11'd0 || loadIR !== 1'b1) begin
            failures++;
            $display("FAIL wrap_pc: pc=%0d ld=%0b, want 0 1", pc, loadIR);
        end
        tick();
    endtask

    task automatic test_reset_mid_req();
        jump = 1'b1; jump_addr = 11'd300;
        tick();
        jump = 1'b0;
        fetch_en = 1'b1; mem_ready = 1'b0;
        tick();
        fetch_en = 1'b0;
        checks++;
        if (mem_rd !== 1'b1 || mem_addr !== 11'd300) begin
            failures++;
            $display("FAIL rstmid_req: rd=%0b addr=%0d, want 1 300", mem_rd, mem_addr);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({mem_rd, mem_addr, insin, loadIR, pc, busy} !== '0) begin
            failures++;
            $display("FAIL rstmid_values: rd=%0b addr=%0d ins=%h ld=%0b pc=%0d busy=%0b, want all zero",
                     mem_rd, mem_addr, insin, loadIR, pc, busy);
        end
        mem_ready = 1'b1; mem_data = 16'hBEEF;
        tick();
        mem_ready = 1'b0;
        checks++;
        if (loadIR !== 1'b0 || mem_rd !== 1'b0 || pc !== 11'd0 || insin !== 16'h0000) begin
            failures++;
            $display("FAIL rstmid_ready: ld=%0b rd=%0b pc=%0d ins=%h, want 0 0 0 0000", loadIR, mem_rd, pc, insin);
        end
    endtask

    task automatic test_random();
        idle_inputs();
        rst = 1'b1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            model_step();
            tick();
            checks++;
            if (mem_rd !== m_req || mem_addr !== m_addr || insin !== m_insin ||
                loadIR !== m_load || pc !== m_pc || busy !== (m_req | m_load)) begin
                failures++;
                $display("FAIL random[%0d]: rd=%0b addr=%0d ins=%h ld=%0b pc=%0d busy=%0b, want %0b %0d %h %0b %0d %0b",
                         cyc, mem_rd, mem_addr, insin, loadIR, pc, busy,
                         m_req, m_addr, m_insin, m_load, m_pc, m_req | m_load);
            end
            rst       = ($urandom_range(0, 79) == 0);
            fetch_en  = ($urandom_range(0, 1) == 1);
            jump      = ($urandom_range(0, 7) == 0);
            jump_addr = AW'($urandom_range(0, 2047));
            if ($urandom_range(0, 5) == 0) jump_addr = 11'd2047;
            mem_ready = ($urandom_range(0, 2) != 0);
            mem_data  = DW'($urandom);
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_basic_fetch();
        test_wait_states();
        test_jump();
        test_abort();
        test_wrap();
        test_reset_mid_req();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
